// File: rtl/game_mode_pkg.sv
// Shared phase encodings, state enum and default timing constants for the
// screen-phase sequencer and the output mux that consumes its select code.
package game_mode_pkg;

   localparam logic [1:0] SEL_START = 2'b00;
   localparam logic [1:0] SEL_GAME  = 2'b01;
   localparam logic [1:0] SEL_END   = 2'b11;

   localparam int DEF_DEB_CYCLES   = 2_000_000;
   localparam int DEF_QUIET_CYCLES = 64;
   localparam int DEF_RST_HOLD     = 16;
   localparam int DEF_TIMEOUT      = 4_000_000;

   typedef enum logic [2:0] {
      ST_HOLD,
      ST_START,
      ST_GAME,
      ST_END,
      ST_DRAIN
   } state_t;

   // Bit order of the per-part vectors: {end, game, start}
   function automatic logic [2:0] phase_onehot(input logic [1:0] code);
      case (code)
         SEL_GAME: phase_onehot = 3'b010;
         SEL_END:  phase_onehot = 3'b100;
         default:  phase_onehot = 3'b001;
      endcase
   endfunction

   function automatic state_t phase_state(input logic [1:0] code);
      case (code)
         SEL_GAME: phase_state = ST_GAME;
         SEL_END:  phase_state = ST_END;
         default:  phase_state = ST_START;
      endcase
   endfunction

endpackage

// File: rtl/game_mode_ctrl_key_debounce.sv
// Two-flop synchroniser followed by a stable-level counter; the output only
// follows the key after DEB_CYCLES consecutive cycles at the new level.
module key_debounce #(
   parameter int DEB_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic level
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], key};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/game_mode_ctrl.sv
// Start/game/end phase sequencer: switches the output mux only once the
// outgoing part's SPI bus is quiet and a VGA frame boundary has passed.
//
// state | meaning
// HOLD  | incoming part held in reset for RST_HOLD cycles, SPI forced idle
// START | start screen running
// GAME  | game running
// END   | end screen running
// DRAIN | switch requested; waiting for SPI quiet + vs fall (or timeout)
module game_mode_ctrl
   import game_mode_pkg::*;
#(
   parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
   parameter int QUIET_CYCLES = DEF_QUIET_CYCLES,
   parameter int RST_HOLD     = DEF_RST_HOLD,
   parameter int TIMEOUT      = DEF_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_game,
   input  logic       game_over,
   input  logic       cur_cs,
   input  logic       cur_dcs,
   input  logic       cur_vs,
   output logic [1:0] sel,
   output logic       start_ena,
   output logic       game_ena,
   output logic       end_ena,
   output logic       start_rst,
   output logic       game_rst,
   output logic       end_rst,
   output logic       spi_hold,
   output logic       forced
);

   localparam int HW = $clog2(RST_HOLD + 1);
   localparam int QW = $clog2(QUIET_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic          play_req;
   logic [1:0]    go_sync;
   logic [1:0]    vs_sync;
   logic          vs_d;
   logic          vs_fall;

   state_t        state, state_nx;
   logic [1:0]    cur, cur_nx, tgt, tgt_nx, sel_nx;
   logic [2:0]    part_ena, part_ena_nx, part_rst, part_rst_nx;
   logic [HW-1:0] hold_cnt, hold_cnt_nx;
   logic [QW-1:0] quiet_cnt, quiet_cnt_nx;
   logic [TW-1:0] drain_cnt, drain_cnt_nx;
   logic          forced_nx;
   logic          quiet_sat, timeout, natural_sw, withdraw, retarget;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_play_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (start_game),
      .level (play_req)
   );

   // vs idles high, so its synchroniser resets high to avoid a false edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         go_sync <= 2'b00;
         vs_sync <= 2'b11;
         vs_d    <= 1'b1;
      end else begin
         go_sync <= {go_sync[0], game_over};
         vs_sync <= {vs_sync[0], cur_vs};
         vs_d    <= vs_sync[1];
      end
   end

   assign vs_fall = vs_d & ~vs_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_HOLD;
         cur       <= SEL_START;
         tgt       <= SEL_START;
         sel       <= SEL_START;
         part_ena  <= 3'b000;
         part_rst  <= 3'b111;
         hold_cnt  <= '0;
         quiet_cnt <= '0;
         drain_cnt <= '0;
         spi_hold  <= 1'b1;
         forced    <= 1'b0;
      end else begin
         state     <= state_nx;
         cur       <= cur_nx;
         tgt       <= tgt_nx;
         sel       <= sel_nx;
         part_ena  <= part_ena_nx;
         part_rst  <= part_rst_nx;
         hold_cnt  <= hold_cnt_nx;
         quiet_cnt <= quiet_cnt_nx;
         drain_cnt <= drain_cnt_nx;
         spi_hold  <= (state_nx == ST_HOLD);
         forced    <= forced_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      cur_nx       = cur;
      tgt_nx       = tgt;
      sel_nx       = sel;
      part_ena_nx  = part_ena;
      part_rst_nx  = part_rst;
      hold_cnt_nx  = '0;
      quiet_cnt_nx = '0;
      drain_cnt_nx = '0;
      forced_nx    = 1'b0;
      quiet_sat    = (quiet_cnt == QW'(QUIET_CYCLES));
      timeout      = (drain_cnt == TW'(TIMEOUT));
      natural_sw   = quiet_sat & vs_fall;
      withdraw     = ((tgt == SEL_GAME) && !play_req) || ((tgt == SEL_START) && play_req);
      retarget     = (tgt == SEL_END) && !play_req;

      case (state)
         ST_HOLD: begin
            if (hold_cnt == HW'(RST_HOLD - 1)) begin
               part_rst_nx = ~phase_onehot(tgt);
               part_ena_nx = phase_onehot(tgt);
               cur_nx      = tgt;
               state_nx    = phase_state(tgt);
            end else begin
               hold_cnt_nx = hold_cnt + HW'(1);
            end
         end
         ST_START: begin
            if (play_req) begin
               tgt_nx   = SEL_GAME;
               state_nx = ST_DRAIN;
            end
         end
         ST_GAME: begin
            if (!play_req) begin
               tgt_nx   = SEL_START;
               state_nx = ST_DRAIN;
            end else if (go_sync[1]) begin
               tgt_nx   = SEL_END;
               state_nx = ST_DRAIN;
            end
         end
         ST_END: begin
            if (!play_req) begin
               tgt_nx   = SEL_START;
               state_nx = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (cur_cs & cur_dcs)
               quiet_cnt_nx = quiet_sat ? quiet_cnt : quiet_cnt + QW'(1);
            drain_cnt_nx = timeout ? drain_cnt : drain_cnt + TW'(1);
            if (withdraw) begin
               state_nx     = phase_state(cur);
               quiet_cnt_nx = '0;
               drain_cnt_nx = '0;
            end else if (retarget) begin
               tgt_nx = SEL_START;
            end else if (natural_sw || timeout) begin
               sel_nx       = tgt;
               part_ena_nx  = 3'b000;
               part_rst_nx  = 3'b111;
               forced_nx    = ~natural_sw;
               quiet_cnt_nx = '0;
               drain_cnt_nx = '0;
               state_nx     = ST_HOLD;
            end
         end
         default: state_nx = ST_HOLD;
      endcase
   end

   assign start_ena = part_ena[0];
   assign game_ena  = part_ena[1];
   assign end_ena   = part_ena[2];
   assign start_rst = part_rst[0];
   assign game_rst  = part_rst[1];
   assign end_rst   = part_rst[2];

endmodule
